// File: rtl/rast_pkg.sv
// Shared defaults and FSM state type for the rasterizer sample walker.
package rast_pkg;

  localparam int SIGFIG_DEF = 24;
  localparam int RADIX_DEF  = 10;
  localparam int VERTS_DEF  = 3;
  localparam int AXIS_DEF   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } walk_state_e;

endpackage

// File: rtl/sample_stream_gen_if.sv
// Triangle/bbox input handshake and sample output stream of sample_stream_gen.
interface sample_stream_gen_if
  import rast_pkg::*;
#(
  parameter int SIGFIG = SIGFIG_DEF,
  parameter int VERTS  = VERTS_DEF,
  parameter int AXIS   = AXIS_DEF
);

  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in_S;
  logic [1:0][1:0][SIGFIG-1:0]            bbox_in_S;
  logic                                   in_valid_H;
  logic                                   in_ready_H;
  logic [3:0]                             subSample_U;
  logic                                   halt_H;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_out_S;
  logic [1:0][SIGFIG-1:0]                 sample_S;
  logic                                   validSamp_H;
  logic                                   last_H;
  logic [31:0]                            smpl_cnt_U;

  modport master (
    output tri_in_S, bbox_in_S, in_valid_H, subSample_U, halt_H,
    input  in_ready_H, tri_out_S, sample_S, validSamp_H, last_H, smpl_cnt_U
  );

  modport slave (
    input  tri_in_S, bbox_in_S, in_valid_H, subSample_U, halt_H,
    output in_ready_H, tri_out_S, sample_S, validSamp_H, last_H, smpl_cnt_U
  );

endinterface

// File: rtl/sample_stream_gen_ss_step_dec.sv
// Combinational decode of one-hot subsample select into grid step and log2 width.
// A zero or multi-hot select resolves by priority, coarsest grid first.
module ss_step_dec
  import rast_pkg::*;
#(
  parameter int SIGFIG = SIGFIG_DEF,
  parameter int RADIX  = RADIX_DEF
) (
  input  logic [3:0]        subSample_i,
  output logic [SIGFIG-1:0] step_o,
  output logic [1:0]        ss_w_lg2_o
);

  always_comb begin
    ss_w_lg2_o = 2'd0;
    if (subSample_i[3])      ss_w_lg2_o = 2'd0;
    else if (subSample_i[2]) ss_w_lg2_o = 2'd1;
    else if (subSample_i[1]) ss_w_lg2_o = 2'd2;
    else if (subSample_i[0]) ss_w_lg2_o = 2'd3;
  end

  assign step_o = {{(SIGFIG-1){1'b0}}, 1'b1} << (RADIX - int'(ss_w_lg2_o));

endmodule

// File: rtl/sample_stream_gen.sv
// Walks a triangle's bbox in raster order emitting one sample per cycle; first sample 1 cycle after accept.
// halt_H freezes all outputs; a new triangle is accepted in the same cycle the previous last sample leaves.
module sample_stream_gen
  import rast_pkg::*;
#(
  parameter int SIGFIG = SIGFIG_DEF,
  parameter int RADIX  = RADIX_DEF,
  parameter int VERTS  = VERTS_DEF,
  parameter int AXIS   = AXIS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  sample_stream_gen_if.slave  io
);

  walk_state_e                             state_q;
  logic                                    valid_q;
  logic                                    last_q;
  logic [31:0]                             cnt_q;
  logic signed [SIGFIG-1:0]                x_q;
  logic signed [SIGFIG-1:0]                y_q;
  logic signed [SIGFIG-1:0]                ll_x_q;
  logic signed [SIGFIG-1:0]                ur_x_q;
  logic signed [SIGFIG-1:0]                ur_y_q;
  logic        [SIGFIG-1:0]                step_q;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_q;

  logic        [SIGFIG-1:0] step_d;
  logic        [1:0]        ss_lg2_d;
  logic        [SIGFIG-1:0] mask_d;
  logic signed [SIGFIG-1:0] ll_x_d;
  logic signed [SIGFIG-1:0] ll_y_d;
  logic signed [SIGFIG-1:0] ur_x_d;
  logic signed [SIGFIG-1:0] ur_y_d;
  logic                     empty_d;
  logic                     ready_d;
  logic                     xfer_d;
  logic                     consume_d;
  logic                     wrap_d;
  logic signed [SIGFIG-1:0] nx_d;
  logic signed [SIGFIG-1:0] ny_d;

  ss_step_dec #(
    .SIGFIG (SIGFIG),
    .RADIX  (RADIX)
  ) u_step_dec (
    .subSample_i (io.subSample_U),
    .step_o      (step_d),
    .ss_w_lg2_o  (ss_lg2_d)
  );

  // Corners are snapped down onto the sample grid so the walk hits ur exactly.
  assign mask_d  = {SIGFIG{1'b1}} << (RADIX - int'(ss_lg2_d));
  assign ll_x_d  = io.bbox_in_S[0][0] & mask_d;
  assign ll_y_d  = io.bbox_in_S[0][1] & mask_d;
  assign ur_x_d  = io.bbox_in_S[1][0] & mask_d;
  assign ur_y_d  = io.bbox_in_S[1][1] & mask_d;
  assign empty_d = (ur_x_d < ll_x_d) || (ur_y_d < ll_y_d);

  assign consume_d = valid_q && !io.halt_H;
  assign ready_d   = rst && ((state_q == ST_IDLE) ||
                             (state_q == ST_WALK && last_q && !io.halt_H));
  assign xfer_d    = io.in_valid_H && ready_d;

  assign wrap_d = (x_q == ur_x_q);
  assign nx_d   = wrap_d ? ll_x_q : x_q + step_q;
  assign ny_d   = wrap_d ? y_q + step_q : y_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ll_x_q  <= '0;
      ur_x_q  <= '0;
      ur_y_q  <= '0;
      step_q  <= '0;
      tri_q   <= '0;
    end else if (xfer_d) begin
      step_q <= step_d;
      ll_x_q <= ll_x_d;
      ur_x_q <= ur_x_d;
      ur_y_q <= ur_y_d;
      if (empty_d) begin
        // Degenerate bbox: swallow the triangle, leave the sample outputs as they were.
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        state_q <= ST_WALK;
        valid_q <= 1'b1;
        x_q     <= ll_x_d;
        y_q     <= ll_y_d;
        tri_q   <= io.tri_in_S;
        last_q  <= (ll_x_d == ur_x_d) && (ll_y_d == ur_y_d);
        cnt_q   <= 32'd1;
      end
    end else if (consume_d) begin
      if (last_q) begin
        state_q <= ST_IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        x_q    <= nx_d;
        y_q    <= ny_d;
        last_q <= (nx_d == ur_x_q) && (ny_d == ur_y_q);
        cnt_q  <= cnt_q + 32'd1;
      end
    end
  end

  assign io.in_ready_H  = ready_d;
  assign io.validSamp_H = valid_q;
  assign io.last_H      = last_q;
  assign io.smpl_cnt_U  = cnt_q;
  assign io.sample_S    = {y_q, x_q};
  assign io.tri_out_S   = tri_q;

endmodule

// File: doc/sample_stream_gen.md
SAMPLE_STREAM_GEN -- requirements
Module: sample_stream_gen

Interface
REQ-001 Parameters: SIGFIG, default 24, bits in position words.
REQ-002 Parameters: RADIX, default 10, fraction bits of position.
REQ-003 Parameters: VERTS, default 3, and AXIS, default 3, triangle array dimensions.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 tri_in_S  in  [VERTS][AXIS]xSIGFIG signed  triangle carried alongside bbox.
REQ-007 bbox_in_S  in  [2][2]xSIGFIG signed  [0]=lower-left (x,y), [1]=upper-right (x,y).
REQ-008 in_valid_H  in  1  triangle/bbox valid; in_ready_H  out  1  block accepts a triangle.
REQ-009 subSample_U  in  4  one-hot step select: [3]=1/pixel, [2]=4, [1]=16, [0]=64 samples.
REQ-010 halt_H  in  1  downstream stall; hold all outputs while high.
REQ-011 tri_out_S  out  [VERTS][AXIS]xSIGFIG  triangle of current sample.
REQ-012 sample_S  out  [2]xSIGFIG signed  sample (x,y); validSamp_H  out  1  sample valid.
REQ-013 last_H  out  1  final sample of triangle; smpl_cnt_U  out  32  samples emitted for current triangle incl. this one.

Function
REQ-014 Step = 1 << (RADIX - ss_w_lg2), ss_w_lg2 = 0/1/2/3 for subSample_U[3]/[2]/[1]/[0].
REQ-015 Transfer on input accepted when in_valid_H && in_ready_H at rising edge; bbox corners latched with bits below step masked to zero.
REQ-016 FSM states IDLE, WALK; IDLE->WALK on input transfer; WALK->IDLE when last sample is consumed (last_H && !halt_H) and no new input transfer that cycle.
REQ-017 in_ready_H = IDLE, or WALK && last_H && !halt_H (back-to-back triangles, zero bubble).
REQ-018 First sample (ll_x, ll_y) presented with validSamp_H=1 the cycle after input transfer.
REQ-019 Raster order: x += step each consumed sample; when x == ur_x, x <= ll_x and y += step; last_H=1 when x == ur_x && y == ur_y.
REQ-020 Sample consumed when validSamp_H && !halt_H; while halt_H=1, sample_S, tri_out_S, last_H, smpl_cnt_U, validSamp_H hold.
REQ-021 smpl_cnt_U = 1 on first sample, +1 per consumed sample; restarts at 1 on new triangle.
REQ-022 ur < ll on either axis (after masking): triangle accepted, no samples emitted, FSM stays IDLE, validSamp_H=0.
REQ-023 ll == ur: exactly one sample with last_H=1 and smpl_cnt_U=1.
REQ-024 subSample_U sampled only at input transfer; changes mid-walk ignored.
REQ-025 Position arithmetic SIGFIG-bit signed; bbox beyond screen is upstream's responsibility, no clamping.
REQ-026 In IDLE outputs validSamp_H=0, last_H=0; sample_S, tri_out_S hold last values.

Reset
REQ-027 rst=0 at rising edge: FSM=IDLE, validSamp_H=0, last_H=0, smpl_cnt_U=0, sample_S=0, tri_out_S=0, in_ready_H=0 during reset cycle, 1 the cycle after release.
REQ-028 Reset mid-walk abandons triangle; no further samples for it after release.

Structure
REQ-029 Package rast_pkg holds SIGFIG, RADIX, VERTS, AXIS defaults and FSM state enum.
REQ-030 Sub-module ss_step_dec: combinational one-hot subSample_U -> step and ss_w_lg2; all state in sample_stream_gen.

Verification
REQ-031 subSample=4'b1000, bbox (0,0)-(2048,1024) -> 6 samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024); last_H on 6th, smpl_cnt_U=6.
REQ-032 subSample=4'b0001, bbox (0,0)-(128,128) -> 4 samples step 128; ll (100,100) masks to (0,0).
REQ-033 halt_H=1 for 3 cycles during sample 2 -> sample 2 held 4 cycles, no sample lost or duplicated.
REQ-034 Two triangles back-to-back, in_valid_H held -> second first sample the cycle after first's last; smpl_cnt_U restarts at 1.
REQ-035 rst=0 at sample 3 of 6 -> validSamp_H=0 next cycle, in_ready_H=1 after release, no residual samples.
REQ-036 bbox ur_x < ll_x -> no validSamp_H, in_ready_H stays 1.
